// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a word-addressed register memory.
// Reads load prdata at the setup edge. Writes commit at the completing edge.
// A configurable number of wait states holds pready low during the access phase.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0). It then
// occupies one or more access cycles (psel=1, penable=1). It completes in the
// single cycle where pready=1, and only that cycle commits a write. Dropping
// psel during access abandons the transfer without side effects.
module apb_slave_mem #(
    parameter int          addrWidth   = 12,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RD_DEFAULT  = 32'hDEAD_BEEF
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [addrWidth-1:0] paddr,
    input  logic [31:0]          pwdata,
    output logic                 pready,
    output logic [31:0]          prdata
);

    localparam int              IDX_W     = addrWidth - 2;
    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]  DEPTH_L   = (IDX_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [0:0]        state;
    logic [3:0]        wait_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [31:0]       mem [DEPTH];

    logic [IDX_W-1:0]  req_idx;
    logic              req_in_range;
    logic              idx_q_in_range;
    logic              setup;
    logic              done;
    logic              wr_en;
    logic [1:0]        unused_addr_lsbs;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n            = rst_sync[1];
    assign unused_addr_lsbs = paddr[1:0];
    assign req_idx          = paddr[addrWidth-1:2];
    assign req_in_range     = ({1'b0, req_idx} < DEPTH_L);
    assign idx_q_in_range   = ({1'b0, idx_q} < DEPTH_L);

    // A setup cycle restarts a transfer in either state. In ACCESS it aborts the old one.
    assign setup  = psel & ~penable;
    assign done   = (state == ST_ACCESS) & psel & penable & (wait_cnt == 4'd0);
    assign pready = done;
    assign wr_en  = done & write_q & idx_q_in_range;

    // Transfer control: latch request at setup, count waits, return to IDLE on completion/abort.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            prdata   <= 32'h0;
        end else if (setup) begin
            idx_q    <= req_idx;
            write_q  <= pwrite;
            wait_cnt <= WAIT_INIT;
            if (!pwrite) begin
                prdata <= req_in_range ? mem[req_idx[MEM_AW-1:0]] : RD_DEFAULT;
            end
            state    <= ST_ACCESS;
        end else if (state == ST_ACCESS) begin
            if (!psel) begin
                state <= ST_IDLE;
            end else if (wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Storage: cleared on reset, written only by a completing in-range write.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (wr_en) begin
            mem[idx_q[MEM_AW-1:0]] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem. Three instances are built with 0, 2 and 3 wait states.
// Each instance has its own psel. All other bus signals are shared.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  pready;
  logic [31:0] prdata [3];

  logic [31:0] exp_q[$];
  logic [31:0] model [3][64];
  int          n_vec  = 0;
  int          n_fail = 0;

  // clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  apb_slave_mem #(.addrWidth(12), .DEPTH(64), .WAIT_STATES(0), .RD_DEFAULT(32'hDEAD_BEEF)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]));

  apb_slave_mem #(.addrWidth(12), .DEPTH(64), .WAIT_STATES(2), .RD_DEFAULT(32'hDEAD_BEEF)) u_ws2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]));

  apb_slave_mem #(.addrWidth(12), .DEPTH(64), .WAIT_STATES(3), .RD_DEFAULT(32'hDEAD_BEEF)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [11:0] addr);
    int idx;
    idx = int'(addr[11:2]);
    return (idx >= 64) ? 32'hDEAD_BEEF : model[d][idx];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 64; i++)
        model[d][i] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      psel = 3'b000; penable = 1'b0;
    end
  endtask

  // One complete transfer on instance d. The bus is left busy afterwards, so back-to-back calls carry no idle cycle.
  task automatic xfer(input int d, input logic wr, input logic [11:0] addr,
                      input logic [31:0] data, input string tag);
    int   cycles;
    int   waits;
    int   idx;
    bit   done;
    logic [31:0] exp;
    @(posedge pclk); #1;
    psel = 3'b000; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data;
    if (!wr) exp_q.push_back(model_read(d, addr));
    #4 check({tag, " setup pready"}, 32'(pready[d]), 32'd0);
    cycles = 1; waits = 0; done = 1'b0;
    while (!done && cycles < 40) begin
      @(posedge pclk); #1;
      penable = 1'b1;
      cycles++;
      #4;
      if (pready[d]) begin
        done = 1'b1;
        if (wr) begin
          idx = int'(addr[11:2]);
          if (idx < 64) model[d][idx] = data;
        end else if (exp_q.size() == 0) begin
          check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          check({tag, " prdata"}, prdata[d], exp);
        end
      end else begin
        waits++;
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " cycles"}, 32'(cycles), 32'(2 + ws_of(d)));
    check({tag, " wait cycles"}, 32'(waits), 32'(ws_of(d)));
  endtask

  initial begin
    presetn = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0;
    model_clear();
    #1 presetn = 1'b0;

    // reset held with random bus activity
    for (int c = 0; c < 3; c++) begin
      @(posedge pclk); #1;
      psel    = 3'($urandom_range(0, 7));
      penable = 1'($urandom_range(0, 1));
      pwrite  = 1'($urandom_range(0, 1));
      paddr   = 12'($urandom_range(0, 4095));
      pwdata  = $urandom;
      #4;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("reset pready d%0d", d), 32'(pready[d]), 32'd0);
        check($sformatf("reset prdata d%0d", d), prdata[d], 32'h0);
      end
    end
    @(posedge pclk); #1;
    psel = 3'b000; penable = 1'b0;
    presetn = 1'b1;
    idle(3);
    xfer(0, 1'b0, 12'h000, 32'h0, "rd0 after reset");

    // basic write/read, zero wait states, back-to-back
    xfer(0, 1'b1, 12'h010, 32'hA5A5_1234, "ws0 wr 010");
    xfer(0, 1'b0, 12'h010, 32'h0, "ws0 rd 010");

    // three wait states
    xfer(2, 1'b1, 12'h004, 32'h0000_00FF, "ws3 wr 004");
    xfer(2, 1'b0, 12'h004, 32'h0, "ws3 rd 004");

    // out of range and misaligned access
    xfer(0, 1'b1, 12'h100, 32'h1234_5678, "oor wr 100");
    xfer(0, 1'b0, 12'h100, 32'h0, "oor rd 100");
    xfer(0, 1'b0, 12'h000, 32'h0, "oor rd 000");
    xfer(0, 1'b0, 12'h0FC, 32'h0, "oor rd 0fc");
    xfer(0, 1'b0, 12'h013, 32'h0, "misaligned rd 013");
    for (int k = 0; k < 4; k++) begin
      xfer(0, 1'b1, 12'($urandom_range(0, 63) * 4), $urandom, "rand wr");
      xfer(0, 1'b0, 12'($urandom_range(0, 127) * 4), 32'h0, "rand rd");
    end
    idle(1);

    // abort after one access cycle, two wait states
    xfer(1, 1'b1, 12'h008, 32'h1111_2222, "ab prior wr");
    @(posedge pclk); #1;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'hFFFF_FFFF;
    #4 check("abort setup pready", 32'(pready[1]), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    #4 check("abort access pready", 32'(pready[1]), 32'd0);
    @(posedge pclk); #1;
    psel = 3'b000; penable = 1'b0;
    #4 check("abort dropped pready", 32'(pready[1]), 32'd0);
    xfer(1, 1'b0, 12'h008, 32'h0, "abort readback");

    // asynchronous reset during an access phase
    @(posedge pclk); #1;
    psel = 3'b101; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h0000_0077;
    @(posedge pclk); #1;
    penable = 1'b1;
    #4;
    check("pre-reset d0 pready", 32'(pready[0]), 32'd1);
    check("pre-reset d2 pready", 32'(pready[2]), 32'd0);
    #1 presetn = 1'b0;
    #1;
    check("async rst d0 pready", 32'(pready[0]), 32'd0);
    check("async rst d2 pready", 32'(pready[2]), 32'd0);
    check("async rst d0 prdata", prdata[0], 32'h0);
    check("async rst d2 prdata", prdata[2], 32'h0);
    @(posedge pclk); #1;
    psel = 3'b000; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    model_clear();
    idle(3);
    xfer(0, 1'b0, 12'h020, 32'h0, "post-rst rd d0 020");
    xfer(0, 1'b0, 12'h010, 32'h0, "post-rst rd d0 010");
    xfer(2, 1'b0, 12'h004, 32'h0, "post-rst rd d2 004");
    xfer(1, 1'b0, 12'h008, 32'h0, "post-rst rd d1 008");
    idle(2);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
